// File: rtl/cpu_control_fsm.sv
// Multi-cycle instruction sequencer: walks each opcode through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes, owns the memory handshake with timeout, and counts retirements.
module cpu_control_fsm #(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                ir_write,
    output logic                pc_write,
    output logic [ALUOP_W-1:0]  aluOP,
    output logic                regWrite,
    output logic                regDestination,
    output logic                aluSource,
    output logic                Branch,
    output logic                memWrite,
    output logic                memToReg,
    output logic                jump,
    output logic                jal,
    output logic                jr,
    output logic                illegal_op,
    output logic                bus_error,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_SLTI = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_XORI = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_JR   = OPCODE_W'(10);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef struct packed {
        logic               mem_req;
        logic               ir_write;
        logic               pc_write;
        logic [ALUOP_W-1:0] aluop;
        logic               reg_write;
        logic               reg_dst;
        logic               alu_src;
        logic               branch;
        logic               mem_write;
        logic               mem_to_reg;
        logic               jump;
        logic               jal;
        logic               jr;
        logic               illegal_op;
        logic               bus_error;
        logic               halted;
    } ctl_t;

    state_t                state;
    logic [OPCODE_W-1:0]   op_q;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [RETIRE_W-1:0]   retired_q;
    logic                  bus_error_q;
    ctl_t                  ctl;

    logic is_legal, is_jump, mem_wait, timeout_hit, retire;

    assign is_legal    = (op_q <= OP_JR);
    assign is_jump     = (op_q == OP_J) || (op_q == OP_JAL) || (op_q == OP_JR);
    assign mem_wait    = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    // Timeout fires on the waiting cycle that would bring the count up to the limit.
    assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait && (int'(wait_cnt) + 1 == MEM_TIMEOUT);
    assign retire      = ((state == S_DECODE) && is_jump)
                       || ((state == S_EXEC) && (op_q == OP_BEQ))
                       || ((state == S_MEM) && (op_q == OP_SW) && mem_ready)
                       || (state == S_WB);

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state       <= S_FETCH;
            op_q        <= '0;
            wait_cnt    <= '0;
            retired_q   <= '0;
            bus_error_q <= 1'b0;
        end else begin
            wait_cnt <= (mem_wait && MEM_TIMEOUT != 0) ? wait_cnt + WAIT_W'(1) : '0;
            if (retire) retired_q <= retired_q + RETIRE_W'(1);

            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        op_q  <= opcode;
                        state <= S_DECODE;
                    end else if (timeout_hit) begin
                        state       <= S_HALT;
                        bus_error_q <= 1'b1;
                    end
                end
                S_DECODE: state <= (!is_legal || is_jump) ? S_FETCH : S_EXEC;
                S_EXEC: begin
                    if (op_q == OP_BEQ)                         state <= S_FETCH;
                    else if ((op_q == OP_LW) || (op_q == OP_SW)) state <= S_MEM;
                    else                                        state <= S_WB;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state <= (op_q == OP_SW) ? S_FETCH : S_WB;
                    end else if (timeout_hit) begin
                        state       <= S_HALT;
                        bus_error_q <= 1'b1;
                    end
                end
                S_WB:    state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        // NOTE: default every field first so no branch of the case can infer a latch.
        ctl           = '0;
        ctl.bus_error = bus_error_q;
        case (state)
            S_FETCH: begin
                ctl.mem_req  = 1'b1;
                ctl.ir_write = mem_ready;
                ctl.pc_write = mem_ready;
            end
            S_DECODE: begin
                ctl.jump       = (op_q == OP_J) || (op_q == OP_JAL);
                ctl.jal        = (op_q == OP_JAL);
                ctl.reg_write  = (op_q == OP_JAL);
                ctl.jr         = (op_q == OP_JR);
                ctl.illegal_op = !is_legal;
            end
            S_EXEC: begin
                ctl.alu_src = (op_q >= OP_LW) && (op_q <= OP_SLTI);
                ctl.branch  = (op_q == OP_BEQ);
                if ((op_q == OP_LW) || (op_q == OP_SW) || (op_q == OP_ADDI)) ctl.aluop = ALUOP_W'(0);
                else if (op_q == OP_BEQ)                                     ctl.aluop = ALUOP_W'(1);
                else                                                         ctl.aluop = ALUOP_W'(2);
            end
            S_MEM: begin
                ctl.mem_req   = 1'b1;
                ctl.mem_write = (op_q == OP_SW);
            end
            S_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = (op_q == OP_R) || (op_q == OP_XORI);
                ctl.mem_to_reg = (op_q == OP_LW);
            end
            S_HALT:  ctl.halted = 1'b1;
            default: ;
        endcase
    end

    // Outputs are forced low for as long as reset is held, not just after the reset edge.
    assign {mem_req, ir_write, pc_write, aluOP, regWrite, regDestination, aluSource, Branch,
            memWrite, memToReg, jump, jal, jr, illegal_op, bus_error, halted} = rst_n ? ctl : '0;
    assign retired_cnt = rst_n ? retired_q : '0;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboarded bench for cpu_control_fsm: a default instance plus a short-timeout,
// 2-bit-retire-counter instance for halt and wrap behaviour.
module tb_cpu_control_fsm;

    typedef enum {T_RST, T_F, T_D, T_E, T_M, T_W, T_H} tst_t;

    typedef struct packed {
        logic        mem_req, ir_write, pc_write;
        logic [1:0]  aluop;
        logic        reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg;
        logic        jump, jal, jr, illegal_op, bus_error, halted;
        logic [31:0] retired;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rdy_a, rst_b, rdy_b;
    logic [5:0]  op_a, op_b;

    logic        a_req, a_irw, a_pcw, a_rw, a_rd, a_as, a_br, a_mw, a_m2r, a_j, a_jal, a_jr, a_ill, a_be, a_h;
    logic [1:0]  a_aluop;
    logic [31:0] a_ret;
    logic        b_req, b_irw, b_pcw, b_rw, b_rd, b_as, b_br, b_mw, b_m2r, b_j, b_jal, b_jr, b_ill, b_be, b_h;
    logic [1:0]  b_aluop;
    logic [1:0]  b_ret;

    cpu_control_fsm dut_a (
        .clk(clk), .rst_n(rst_a), .opcode(op_a), .mem_ready(rdy_a),
        .mem_req(a_req), .ir_write(a_irw), .pc_write(a_pcw), .aluOP(a_aluop),
        .regWrite(a_rw), .regDestination(a_rd), .aluSource(a_as), .Branch(a_br),
        .memWrite(a_mw), .memToReg(a_m2r), .jump(a_j), .jal(a_jal), .jr(a_jr),
        .illegal_op(a_ill), .bus_error(a_be), .halted(a_h), .retired_cnt(a_ret)
    );

    cpu_control_fsm #(.MEM_TIMEOUT(4), .RETIRE_W(2)) dut_b (
        .clk(clk), .rst_n(rst_b), .opcode(op_b), .mem_ready(rdy_b),
        .mem_req(b_req), .ir_write(b_irw), .pc_write(b_pcw), .aluOP(b_aluop),
        .regWrite(b_rw), .regDestination(b_rd), .aluSource(b_as), .Branch(b_br),
        .memWrite(b_mw), .memToReg(b_m2r), .jump(b_j), .jal(b_jal), .jr(b_jr),
        .illegal_op(b_ill), .bus_error(b_be), .halted(b_h), .retired_cnt(b_ret)
    );

    obs_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned ret_a    = 0;
    int unsigned ret_b    = 0;

    // Expected strobes for one cycle, straight from the per-state control table.
    function automatic obs_t model(tst_t st, logic [5:0] op, logic rdy, logic [31:0] ret);
        obs_t o;
        o = '0;
        if (st == T_RST) return o;
        o.retired = ret;
        case (st)
            T_F: begin o.mem_req = 1'b1; o.ir_write = rdy; o.pc_write = rdy; end
            T_D: begin
                o.jump       = (op == 6'h08) || (op == 6'h09);
                o.jal        = (op == 6'h09);
                o.reg_write  = (op == 6'h09);
                o.jr         = (op == 6'h0A);
                o.illegal_op = (op > 6'h0A);
            end
            T_E: begin
                o.alu_src = (op >= 6'h02) && (op <= 6'h07);
                o.branch  = (op == 6'h01);
                o.aluop   = (op == 6'h02 || op == 6'h03 || op == 6'h04) ? 2'b00 :
                            (op == 6'h01) ? 2'b01 : 2'b10;
            end
            T_M: begin o.mem_req = 1'b1; o.mem_write = (op == 6'h03); end
            T_W: begin
                o.reg_write  = 1'b1;
                o.reg_dst    = (op == 6'h00) || (op == 6'h06);
                o.mem_to_reg = (op == 6'h02);
            end
            T_H: begin o.halted = 1'b1; o.bus_error = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic obs_t observe(bit b);
        if (b)
            return {b_req, b_irw, b_pcw, b_aluop, b_rw, b_rd, b_as, b_br, b_mw, b_m2r,
                    b_j, b_jal, b_jr, b_ill, b_be, b_h, 30'd0, b_ret};
        return {a_req, a_irw, a_pcw, a_aluop, a_rw, a_rd, a_as, a_br, a_mw, a_m2r,
                a_j, a_jal, a_jr, a_ill, a_be, a_h, a_ret};
    endfunction

    // One clock cycle: drive inputs, queue the expectation, compare mid-cycle.
    task automatic step(input bit b, input string tag, input tst_t st, input logic [5:0] iop, input logic rdy);
        logic [5:0] drv;
        obs_t       exp_o, act_o;
        drv = (st == T_F) ? iop : 6'($urandom);
        if (b) begin rst_b = (st != T_RST); op_b = drv; rdy_b = rdy; end
        else   begin rst_a = (st != T_RST); op_a = drv; rdy_a = rdy; end
        sb_q.push_back(model(st, iop, rdy, b ? 32'(ret_b % 4) : ret_a));
        @(negedge clk);
        exp_o = sb_q.pop_front();
        act_o = observe(b);
        n_checks++;
        if (act_o !== exp_o) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", tag, b, $time, act_o, exp_o);
        end
        @(posedge clk);
        #1;
        if (st == T_RST) begin
            if (b) ret_b = 0;
            else   ret_a = 0;
        end
    endtask

    task automatic bump(input bit b);
        if (b) ret_b++;
        else   ret_a++;
    endtask

    task automatic run_instr(input bit b, input logic [5:0] op, input int fetch_wait, input int mem_wait);
        for (int i = 0; i < fetch_wait; i++) step(b, "fetch_wait", T_F, op, 1'b0);
        step(b, "fetch", T_F, op, 1'b1);
        step(b, "decode", T_D, op, 1'b1);
        if (op > 6'h0A) return;
        if (op >= 6'h08) begin bump(b); return; end
        step(b, "exec", T_E, op, 1'b1);
        if (op == 6'h01) begin bump(b); return; end
        if (op == 6'h02 || op == 6'h03) begin
            for (int i = 0; i < mem_wait; i++) step(b, "mem_wait", T_M, op, 1'b0);
            step(b, "mem_done", T_M, op, 1'b1);
            if (op == 6'h03) begin bump(b); return; end
        end
        step(b, "writeback", T_W, op, 1'b1);
        bump(b);
    endtask

    task automatic test_reset;
        step(0, "reset", T_RST, 6'h00, 1'b1);
        step(0, "reset_hold", T_RST, 6'h00, 1'b0);
    endtask

    task automatic test_lw;
        run_instr(0, 6'h02, 0, 0);
    endtask

    task automatic test_jal;
        run_instr(0, 6'h09, 0, 0);
    endtask

    task automatic test_illegal;
        run_instr(0, 6'h3F, 0, 0);
        step(0, "illegal_next_fetch", T_F, 6'h00, 1'b0);
    endtask

    task automatic test_sw_delayed;
        run_instr(0, 6'h03, 0, 5);
    endtask

    task automatic test_back_to_back;
        logic [5:0] ops [10];
        ops = '{6'h01, 6'h08, 6'h00, 6'h04, 6'h05, 6'h06, 6'h07, 6'h0A, 6'h02, 6'h03};
        for (int i = 0; i < 10; i++) run_instr(0, ops[i], i % 3, i % 2);
        step(0, "b2b_tail", T_F, 6'h00, 1'b0);
    endtask

    task automatic test_reset_mid_mem;
        step(0, "lw_fetch", T_F, 6'h02, 1'b1);
        step(0, "lw_decode", T_D, 6'h02, 1'b1);
        step(0, "lw_exec", T_E, 6'h02, 1'b1);
        step(0, "lw_mem_wait", T_M, 6'h02, 1'b0);
        step(0, "mid_mem_reset", T_RST, 6'h02, 1'b1);
        run_instr(0, 6'h08, 0, 0);
        step(0, "post_reset_fetch", T_F, 6'h00, 1'b0);
    endtask

    task automatic test_timeout;
        step(1, "to_reset", T_RST, 6'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(1, "to_fetch_wait", T_F, 6'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1, "to_halt", T_H, 6'h00, 1'($urandom));
        step(1, "to_reset_halt", T_RST, 6'h00, 1'b1);
        run_instr(1, 6'h08, 3, 0);
        run_instr(1, 6'h09, 0, 0);
        run_instr(1, 6'h0A, 0, 0);
        run_instr(1, 6'h01, 0, 0);
        run_instr(1, 6'h02, 0, 3);
        step(1, "to_lw_fetch", T_F, 6'h02, 1'b1);
        step(1, "to_lw_decode", T_D, 6'h02, 1'b1);
        step(1, "to_lw_exec", T_E, 6'h02, 1'b1);
        for (int i = 0; i < 4; i++) step(1, "to_mem_wait", T_M, 6'h02, 1'b0);
        for (int i = 0; i < 2; i++) step(1, "to_mem_halt", T_H, 6'h02, 1'b1);
        step(1, "to_reset_final", T_RST, 6'h00, 1'b0);
        step(1, "to_fetch_after", T_F, 6'h00, 1'b0);
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        rdy_a = 1'b0; rdy_b = 1'b0;
        op_a  = '0;   op_b  = '0;
        @(posedge clk);
        #1;
        test_reset;
        test_lw;
        test_jal;
        test_illegal;
        test_sw_delayed;
        test_back_to_back;
        test_reset_mid_mem;
        test_timeout;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
